// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a mode-0 initiator and the flash responder.
// Signal names match the external flash pins.
interface spi_flash_responder_if;
  logic SPI_CLK;
  logic CS_n;
  logic MOSI;
  logic MISO;

  modport master (
    output SPI_CLK,
    output CS_n,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SPI_CLK,
    input  CS_n,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/spi_flash_responder.sv
// Oversampled SPI mode-0 target emulating a serial flash READ (0x03).
// All logic runs on sys_clk; SPI pins are synchronized and edge-detected.
module spi_flash_responder #(
  parameter int MEM_DEPTH   = 16,
  parameter int ADDR_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  spi_flash_responder_if.slave spi,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 rd_strobe,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } t_state_e;

  t_state_e r_state;
  t_state_e w_state_nx;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic                 w_sck;
  logic                 w_cs;
  logic                 w_mosi;
  logic                 w_sck_rise;
  logic                 w_sck_fall;
  logic                 w_cs_rise;
  logic                 w_cs_fall;
  logic [7:0]           w_shift_nx;

  logic [4:0]           r_bit_cnt;
  logic [6:0]           r_shift;
  logic [7:0]           r_tx;
  logic                 r_miso;
  logic [ADDR_BITS-1:0] r_index;
  logic                 r_rd_strobe;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic                 r_cmd_err;

  logic [7:0] r_mem [MEM_DEPTH];

  // CS_n flops reset high so busy reads idle out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi.SPI_CLK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.CS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;
  assign w_cs_fall  = ~w_cs & r_cs_d;

  // Only the command and the low ADDR_BITS address bits matter.
  assign w_shift_nx = {r_shift, w_mosi};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_cs_rise) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE:
          if (w_cs_fall) w_state_nx = CMD;
        CMD:
          if (w_sck_rise && r_bit_cnt == 5'd7)
            w_state_nx = (w_shift_nx == 8'h03) ? ADDR : IGNORE;
        ADDR:
          if (w_sck_rise && r_bit_cnt == 5'd23)
            w_state_nx = DATA;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_index     <= '0;
      r_rd_strobe <= 1'b0;
      r_rd_addr   <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_rd_strobe <= 1'b0;
      r_cmd_err   <= 1'b0;
      if (w_cs_rise) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_miso <= 1'b0;
            if (w_cs_fall) begin
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end
          CMD: begin
            r_miso <= 1'b0;
            if (w_sck_rise) begin
              r_shift <= w_shift_nx[6:0];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_cmd_err <= (w_shift_nx != 8'h03);
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            r_miso <= 1'b0;
            if (w_sck_rise) begin
              r_shift <= w_shift_nx[6:0];
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= '0;
                r_index   <= w_shift_nx[ADDR_BITS-1:0];
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          DATA: begin
            if (w_sck_rise) begin
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_index   <= r_index + 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
            // A fall at bit 0 starts a new byte; later falls shift it out.
            if (w_sck_fall) begin
              if (r_bit_cnt == 5'd0) begin
                r_tx        <= r_mem[r_index];
                r_miso      <= r_mem[r_index][7];
                r_rd_strobe <= 1'b1;
                r_rd_addr   <= r_index;
              end else begin
                r_tx   <= {r_tx[6:0], 1'b0};
                r_miso <= r_tx[6];
              end
            end
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

  // Array is never reset; a same-cycle write lands after the load reads it.
  always_ff @(posedge sys_clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign spi.MISO  = r_miso;
  assign busy      = ~w_cs;
  assign rd_strobe = r_rd_strobe;
  assign rd_addr   = r_rd_addr;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: mode-0 initiator model,
// reference byte array and expected-byte / expected-index scoreboards.
module tb_spi_flash_responder;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       rd_strobe;
  logic [3:0] rd_addr;
  logic       cmd_err;

  spi_flash_responder_if sif ();

  spi_flash_responder #(
    .MEM_DEPTH  (16),
    .ADDR_BITS  (4),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .spi      (sif),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .rd_strobe(rd_strobe),
    .rd_addr  (rd_addr),
    .cmd_err  (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_err = 0;
  logic [7:0] mdl [16];
  logic [7:0] exp_q [$];
  logic [3:0] addr_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rd_strobe === 1'b1) begin
        n_strobe++;
        if (addr_q.size() == 0)
          chk("rd_strobe_unexpected", {31'b0, rd_strobe}, 32'h0);
        else
          chk("rd_addr", {28'b0, rd_addr}, {28'b0, addr_q.pop_front()});
      end
      if (cmd_err === 1'b1) n_err++;
    end
  end

  task automatic half();
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge sys_clk);
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic bit_x(input logic b, input logic fall, output logic r);
    sif.MOSI = b;
    half();
    r = sif.MISO;
    sif.SPI_CLK = 1'b1;
    half();
    if (fall) sif.SPI_CLK = 1'b0;
  endtask

  task automatic byte_x(input logic [7:0] tx, input logic fall_last,
                        output logic [7:0] rx);
    for (int i = 7; i >= 0; i--)
      bit_x(tx[i], (i != 0) || fall_last, rx[i]);
  endtask

  task automatic cs_low();
    sif.CS_n = 1'b0;
    half();
  endtask

  // Final SCK fall coincides with CS_n rise, so no trailing load occurs.
  task automatic cs_end();
    sif.SPI_CLK = 1'b0;
    sif.CS_n = 1'b1;
    half();
  endtask

  task automatic header(input logic [23:0] a);
    logic [7:0] d;
    byte_x(8'h03, 1'b1, d);
    byte_x(a[23:16], 1'b1, d);
    byte_x(a[15:8], 1'b1, d);
    byte_x(a[7:0], 1'b1, d);
  endtask

  task automatic rd(input logic [23:0] a, input int n);
    logic [7:0] rx;
    logic [3:0] idx;
    int s0;
    s0 = n_strobe;
    for (int k = 0; k < n; k++) begin
      idx = a[3:0] + 4'(k);
      exp_q.push_back(mdl[idx]);
      addr_q.push_back(idx);
    end
    cs_low();
    chk("busy_high", {31'b0, busy}, 32'h1);
    header(a);
    for (int k = 0; k < n; k++) begin
      byte_x(8'h00, k != n - 1, rx);
      chk("data", {24'b0, rx}, {24'b0, exp_q.pop_front()});
    end
    cs_end();
    chk("busy_low", {31'b0, busy}, 32'h0);
    chk("strobe_count", n_strobe - s0, n);
  endtask

  initial begin
    logic [7:0] rx;
    logic [3:0] nib;
    logic       b;
    int s0;
    int e0;
    sif.CS_n = 1'b1;
    sif.SPI_CLK = 1'b0;
    sif.MOSI = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_miso", {31'b0, sif.MISO}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_strobe", {31'b0, rd_strobe}, 32'h0);
    chk("rst_rd_addr", {28'b0, rd_addr}, 32'h0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'h0);
    sys_rst_n = 1'b1;
    half();

    wr(4'd5, 8'hA5);
    wr(4'd15, 8'h3C);
    wr(4'd0, 8'hC3);
    wr(4'd2, 8'h5A);
    wr(4'd1, 8'h81);
    wr(4'd3, 8'h96);

    rd(24'h000005, 1);
    chk("rd_addr_hold_5", {28'b0, rd_addr}, 32'h5);

    rd(24'h00000F, 2);
    chk("rd_addr_wrap_0", {28'b0, rd_addr}, 32'h0);

    s0 = n_strobe;
    e0 = n_err;
    cs_low();
    byte_x(8'h9F, 1'b1, rx);
    for (int k = 0; k < 3; k++) begin
      byte_x(8'hFF, 1'b1, rx);
      chk("ignore_miso", {24'b0, rx}, 32'h0);
    end
    cs_end();
    chk("cmd_err_count", n_err - e0, 1);
    chk("ignore_strobes", n_strobe - s0, 0);

    rd(24'hFFFF02, 1);

    s0 = n_strobe;
    addr_q.push_back(4'd3);
    cs_low();
    header(24'h000003);
    for (int i = 3; i >= 0; i--) begin
      bit_x(1'b0, 1'b1, b);
      nib[i] = b;
    end
    cs_end();
    chk("partial_bits", {28'b0, nib}, {28'b0, mdl[3][7:4]});
    chk("partial_busy", {31'b0, busy}, 32'h0);
    chk("partial_strobes", n_strobe - s0, 1);
    rd(24'h000001, 1);

    cs_low();
    byte_x(8'h03, 1'b1, rx);
    byte_x(8'h00, 1'b1, rx);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_miso", {31'b0, sif.MISO}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    sif.CS_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    half();
    rd(24'h000005, 1);
    chk("addr_q_drained", addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
